// File: rtl/multi_vector_constructor.sv
// Multi-channel vector assembler: streams elements from per-channel synchronous RAM
// reads into D-wide vectors with valid/accept handshake and a global advance enable.
module multi_vector_constructor #(
  parameter int unsigned ELEMENT_WIDTH    = 24,
  parameter int unsigned ADDR_WIDTH       = 8,
  parameter int unsigned VECTOR_DIMENSION = 3,
  parameter int unsigned NUM_CHANNELS     = 2
) (
  input  logic                                                        clk,
  input  logic                                                        reset,
  input  logic                                                        enabled,
  input  logic                                                        start,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]                     base_addr,
  input  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]                     expected_elements,
  input  logic [NUM_CHANNELS-1:0][ELEMENT_WIDTH-1:0]                  element_in,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]                     addr,
  output logic [NUM_CHANNELS-1:0][VECTOR_DIMENSION-1:0][ELEMENT_WIDTH-1:0] vector,
  output logic [NUM_CHANNELS-1:0]                                     vector_valid,
  input  logic [NUM_CHANNELS-1:0]                                     vector_accept,
  output logic                                                        busy,
  output logic                                                        done
);

  localparam int unsigned N      = NUM_CHANNELS;
  localparam int unsigned D      = VECTOR_DIMENSION;
  localparam int unsigned SLOT_W = (D > 1) ? $clog2(D) : 1;

  typedef enum logic [1:0] {T_IDLE = 2'd0, T_RUN = 2'd1, T_FINISH = 2'd2} top_state_e;
  typedef enum logic [1:0] {CH_DONE = 2'd0, CH_FETCH = 2'd1, CH_HOLD = 2'd2} ch_state_e;

  top_state_e r_state, w_state_nxt;
  ch_state_e  r_ch     [N];
  ch_state_e  w_ch_nxt [N];

  logic [ADDR_WIDTH-1:0]    r_addr    [N];
  logic [ADDR_WIDTH-1:0]    r_iss_rem [N];
  logic [ADDR_WIDTH-1:0]    r_cap_rem [N];
  logic [SLOT_W-1:0]        r_vec_iss [N];
  logic [SLOT_W-1:0]        r_slot    [N];
  logic [ELEMENT_WIDTH-1:0] r_vec     [N][D];
  logic [N-1:0]             r_addr_vld, r_pend, r_vv;
  logic                     r_busy, r_done, w_busy_nxt, w_done_nxt;
  logic                     w_start_acc;
  logic [N-1:0]             w_consume, w_capture, w_last_cap, w_xfer, w_ch_done;

  assign w_start_acc = enabled & start & (r_state == T_IDLE);

  // Per-channel events: address consumed by RAM, data captured, vector complete, vector handed off
  always_comb begin
    for (int unsigned c = 0; c < N; c++) begin
      w_consume[c]  = enabled & (r_ch[c] == CH_FETCH) & r_addr_vld[c];
      w_capture[c]  = enabled & r_pend[c];
      w_last_cap[c] = w_capture[c] & ((r_slot[c] == SLOT_W'(D - 1)) |
                                      (r_cap_rem[c] == ADDR_WIDTH'(1)));
      w_xfer[c]     = enabled & (r_ch[c] == CH_HOLD) & r_vv[c] & vector_accept[c];
      w_ch_done[c]  = (r_ch[c] == CH_DONE);
    end
  end

  // Channel state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned c = 0; c < N; c++) r_ch[c] <= CH_DONE;
    end else begin
      for (int unsigned c = 0; c < N; c++) r_ch[c] <= w_ch_nxt[c];
    end
  end

  // Channel next state
  always_comb begin
    for (int unsigned c = 0; c < N; c++) begin
      w_ch_nxt[c] = r_ch[c];
      if (w_start_acc) begin
        w_ch_nxt[c] = (expected_elements[c] == '0) ? CH_DONE : CH_FETCH;
      end else begin
        case (r_ch[c])
          CH_FETCH: if (w_last_cap[c]) w_ch_nxt[c] = CH_HOLD;
          CH_HOLD:  if (w_xfer[c]) w_ch_nxt[c] = (r_cap_rem[c] == '0) ? CH_DONE : CH_FETCH;
          default:  w_ch_nxt[c] = r_ch[c];
        endcase
      end
    end
  end

  // Channel datapath; a vector's next address is only re-armed once the current one is handed off
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr_vld <= '0;
      r_pend     <= '0;
      r_vv       <= '0;
      for (int unsigned c = 0; c < N; c++) begin
        r_addr[c]    <= '0;
        r_iss_rem[c] <= '0;
        r_cap_rem[c] <= '0;
        r_vec_iss[c] <= '0;
        r_slot[c]    <= '0;
        for (int unsigned d = 0; d < D; d++) r_vec[c][d] <= '0;
      end
    end else if (w_start_acc) begin
      r_pend <= '0;
      r_vv   <= '0;
      for (int unsigned c = 0; c < N; c++) begin
        r_addr[c]     <= base_addr[c];
        r_addr_vld[c] <= (expected_elements[c] != '0);
        r_iss_rem[c]  <= expected_elements[c];
        r_cap_rem[c]  <= expected_elements[c];
        r_vec_iss[c]  <= '0;
        r_slot[c]     <= '0;
      end
    end else if (enabled) begin
      r_pend <= w_consume;
      for (int unsigned c = 0; c < N; c++) begin
        if (w_consume[c]) begin
          r_addr[c]    <= r_addr[c] + ADDR_WIDTH'(1);
          r_iss_rem[c] <= r_iss_rem[c] - ADDR_WIDTH'(1);
          if ((r_vec_iss[c] == SLOT_W'(D - 1)) || (r_iss_rem[c] == ADDR_WIDTH'(1))) begin
            r_addr_vld[c] <= 1'b0;
            r_vec_iss[c]  <= '0;
          end else begin
            r_vec_iss[c]  <= r_vec_iss[c] + SLOT_W'(1);
          end
        end
        if (w_capture[c]) begin
          r_cap_rem[c] <= r_cap_rem[c] - ADDR_WIDTH'(1);
          // Slot 0 capture clears the rest so a short final vector is zero-padded
          for (int unsigned d = 0; d < D; d++) begin
            if (r_slot[c] == '0) begin
              r_vec[c][d] <= (d == 0) ? element_in[c] : '0;
            end else if (r_slot[c] == SLOT_W'(d)) begin
              r_vec[c][d] <= element_in[c];
            end
          end
          if (w_last_cap[c]) begin
            r_slot[c] <= '0;
            r_vv[c]   <= 1'b1;
          end else begin
            r_slot[c] <= r_slot[c] + SLOT_W'(1);
          end
        end
        if (w_xfer[c]) begin
          r_vv[c]       <= 1'b0;
          r_addr_vld[c] <= (r_cap_rem[c] != '0);
        end
      end
    end
  end

  // Top state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= T_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Top next state
  always_comb begin
    w_state_nxt = r_state;
    if (enabled) begin
      case (r_state)
        T_IDLE:   if (start) w_state_nxt = T_RUN;
        T_RUN:    if (&w_ch_done) w_state_nxt = T_FINISH;
        T_FINISH: w_state_nxt = T_IDLE;
        default:  w_state_nxt = T_IDLE;
      endcase
    end
  end

  // Top outputs
  always_comb begin
    w_busy_nxt = r_busy;
    w_done_nxt = r_done;
    if (enabled) begin
      w_done_nxt = 1'b0;
      case (r_state)
        T_IDLE: if (start) w_busy_nxt = 1'b1;
        T_RUN: begin
          if (&w_ch_done) begin
            w_busy_nxt = 1'b0;
            w_done_nxt = 1'b1;
          end
        end
        default: w_busy_nxt = r_busy;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  for (genvar c = 0; c < int'(N); c++) begin : g_ch
    assign addr[c] = r_addr[c];
    for (genvar d = 0; d < int'(D); d++) begin : g_slot
      assign vector[c][d] = r_vec[c][d];
    end
  end

  assign vector_valid = r_vv;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: doc/multi_vector_constructor.md
MULTI_VECTOR_CONSTRUCTOR -- requirements
Module: multi_vector_constructor

Interface
REQ-001 Parameter ELEMENT_WIDTH, default 24, bit width of one vector element.
REQ-002 Parameter ADDR_WIDTH, default 8, width of each element-memory read address.
REQ-003 Parameter VECTOR_DIMENSION, default 3, number of elements per vector (D), D >= 1.
REQ-004 Parameter NUM_CHANNELS, default 2, number of independent read channels (N), N >= 1.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enabled  input  1  global advance enable; low freezes all state.
REQ-008 start  input  1  single-cycle request to begin a job on all channels.
REQ-009 base_addr  input  N x ADDR_WIDTH  per-channel start address, sampled on accepted start.
REQ-010 expected_elements  input  N x ADDR_WIDTH  per-channel element count, sampled on accepted start.
REQ-011 element_in  input  N x ELEMENT_WIDTH  per-channel read data from a synchronous RAM with 1-cycle read latency.
REQ-012 addr  output  N x ADDR_WIDTH  per-channel registered read address.
REQ-013 vector  output  N x D x ELEMENT_WIDTH  per-channel assembled vector, slot 0 = lowest address.
REQ-014 vector_valid  output  N  per-channel vector available.
REQ-015 vector_accept  input  N  per-channel consumer accept; transfer when vector_valid & vector_accept & enabled.
REQ-016 busy  output  1  high from accepted start until done.
REQ-017 done  output  1  one-cycle pulse when the job completes.

Function
REQ-018 Top FSM states IDLE, RUN, FINISH; start accepted only when IDLE, enabled high; start in RUN/FINISH or with enabled low is ignored.
REQ-019 On accepted start: latch base/count per channel, addr[c] <= base_addr[c], state -> RUN, busy <= 1.
REQ-020 Per-channel FSM states FETCH, HOLD, CHDONE; a channel with count 0 enters CHDONE directly and emits no vector.
REQ-021 FETCH: one address per enabled cycle, addr increments by 1 modulo 2^ADDR_WIDTH; data captured into slot (k mod D) the cycle after its address is presented.
REQ-022 Address issue stops after D addresses per vector or after the final element; no read beyond base + count - 1 is used.
REQ-023 When D elements captured, or the final element captured, vector_valid rises the next cycle; unfilled slots of a final partial vector are zero.
REQ-024 With enabled held high and vector_accept high, first vector_valid occurs D+1 cycles after the start edge; steady state one element per cycle per channel.
REQ-025 HOLD: vector and vector_valid stay stable until accepted; on acceptance, go to FETCH if elements remain, else CHDONE.
REQ-026 Addressing of the next vector resumes no earlier than acceptance of the current one; no element is lost or duplicated under any pattern of backpressure.
REQ-027 enabled low: no register changes (addr, slots, counters, FSMs, outputs hold); any pause length produces the same vector sequence as without pause.
REQ-028 Channels advance independently; one channel stalling never stalls another.
REQ-029 When all channels are in CHDONE, top enters FINISH: done = 1 for exactly one enabled cycle, busy <= 0, then IDLE.
REQ-030 start coincident with done is ignored.

Reset
REQ-031 reset low asynchronously forces: top IDLE, all channels CHDONE, addr = 0, vector slots = 0, vector_valid = 0, busy = 0, done = 0.
REQ-032 reset asserted mid-job discards the job; after release the block accepts a new start with no residual state.

Verification
REQ-033 RAM[0..14] = AA00,1B480,5916,15F0,45557E,20000,44378,ECC0,DDDC4,1738,173800,17380,82F80,90000,99999; ch0 base 0 count 6, ch1 base 6 count 9, accept tied high -> ch0 {AA00,1B480,5916},{15F0,45557E,20000}; ch1 {44378,ECC0,DDDC4},{1738,173800,17380},{82F80,90000,99999}; one done pulse.
REQ-034 ch0 base 0 count 4, ch1 count 0 -> ch0 {AA00,1B480,5916},{15F0,0,0}; ch1 no vector_valid; done after ch0's second accept.
REQ-035 ch0 base 0xFE count 3 with RAM[FE]=1, RAM[FF]=2, RAM[00]=AA00 -> addr sequence FE,FF,00; vector {1,2,AA00}.
REQ-036 Scenario REQ-033 with vector_accept low on ch1 for 10 cycles per vector and enabled toggled every 3 cycles -> identical vectors, ch0 unaffected by ch1 stall.
REQ-037 reset pulsed low during ch1's second vector, then new start ch0 base 3 count 3 -> all outputs reset immediately; single vector {15F0,45557E,20000} then done.
REQ-038 start reasserted while busy -> ignored; base/count unchanged; vector sequence matches the single-start run.
